// File: rtl/dem_bcd_0_59.sv
// Two-digit BCD up-counter (00..TENS_MAX/UNITS_MAX, default 00..59) with a carry strobe for cascading.
// Optional DEM_BCD_TICK_EDGE_EN: count on rising edges of tick instead of while tick is high.
module dem_bcd_0_59 #(
    parameter logic [3:0] UNITS_MAX = 4'd9,
    parameter logic [3:0] TENS_MAX  = 4'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    output logic [3:0] q1,
    output logic [3:0] q0,
    output logic       max_tick
);

    logic [3:0] q0_reg, q0_next;
    logic [3:0] q1_reg, q1_next;
    logic       tick_qual;
    logic       at_max;
    logic       illegal;

`ifdef DEM_BCD_TICK_EDGE_EN
    logic tick_d_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_d_reg <= 1'b0;
        end else begin
            tick_d_reg <= tick;
        end
    end

    assign tick_qual = tick && !tick_d_reg;
`else
    assign tick_qual = tick;
`endif

    // Terminal count and out-of-range detection use only registered digits, so max_tick cannot glitch on q updates.
    assign at_max  = (q1_reg == TENS_MAX) && (q0_reg == UNITS_MAX);
    assign illegal = (q0_reg > UNITS_MAX) || (q1_reg > TENS_MAX);

    always_comb begin
        q0_next = q0_reg;
        q1_next = q1_reg;
        if (tick_qual) begin
            if (illegal) begin
                q0_next = 4'd0;
                q1_next = 4'd0;
            end else if (q0_reg < UNITS_MAX) begin
                q0_next = q0_reg + 4'd1;
            end else begin
                q0_next = 4'd0;
                if (q1_reg < TENS_MAX) begin
                    q1_next = q1_reg + 4'd1;
                end else begin
                    q1_next = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q0_reg <= 4'd0;
            q1_reg <= 4'd0;
        end else begin
            q0_reg <= q0_next;
            q1_reg <= q1_next;
        end
    end

    assign q0       = q0_reg;
    assign q1       = q1_reg;
    assign max_tick = tick_qual && at_max && !reset;

endmodule

// File: tb/tb_dem_bcd_0_59.sv
// Directed self-checking bench for dem_bcd_0_59 (modulo-60 default plus a modulo-30 instance).
`timescale 1ns/1ps
module tb_dem_bcd_0_59;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [3:0] q1, q0;
    logic       max_tick;
    logic [3:0] m30_q1, m30_q0;
    logic       m30_max_tick;

    int checks_total;
    int checks_passed;

    dem_bcd_0_59 u_dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .q1       (q1),
        .q0       (q0),
        .max_tick (max_tick)
    );

    dem_bcd_0_59 #(.UNITS_MAX(4'd9), .TENS_MAX(4'd2)) u_mod30 (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .q1       (m30_q1),
        .q0       (m30_q0),
        .max_tick (m30_max_tick)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            checks_passed++;
            $display("ok   %s: %0h (t=%0t)", tag, got, $time);
        end
    endtask

    // One qualified count: tick high for one edge, then low for one edge (40 ns per count).
    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    int max_cnt;

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset = 1'b0;
        tick  = 1'b0;

        // Test 1: asynchronous reset, before any clock edge
        #1 reset = 1'b1;
        tick = 1'b1;
        #1;
        check("rst_async_q", {q1, q0}, 8'h00);
        check("rst_async_max", max_tick, 1'b0);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        check("rst_hold_q", {q1, q0}, 8'h00);
        tick  = 1'b0;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_q", {q1, q0}, 8'h00);
        pulse(1);
        check("first_tick", {q1, q0}, 8'h01);
        pulse(22);
        check("count_23", {q1, q0}, 8'h23);
        reset = 1'b1;
        #2;
        check("rst_mid_async", {q1, q0}, 8'h00);
        tick = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_mid_hold", {q1, q0}, 8'h00);
        tick  = 1'b0;
        reset = 1'b0;

        // Test 2: alternate-edge ticks, 10 counts
        pulse(10);
        check("count_10", {q1, q0}, 8'h10);
        check("count_10_max", max_tick, 1'b0);

        // Test 3 / 6: full wrap of both instances
        do_reset();
        pulse(29);
        check("m30_at_29", {m30_q1, m30_q0}, 8'h29);
        check("m60_at_29", {q1, q0}, 8'h29);
        tick = 1'b1;
        #1;
        check("m30_max_29", m30_max_tick, 1'b1);
        check("m60_nomax_29", max_tick, 1'b0);
        tick = 1'b0;
        #1;
        check("m30_max_notick", m30_max_tick, 1'b0);
        pulse(30);
        check("at_59", {q1, q0}, 8'h59);
        check("m30_wrapped", {m30_q1, m30_q0}, 8'h29);
        check("max_59_notick", max_tick, 1'b0);
        tick = 1'b1;
        #1;
        check("max_59_tick", max_tick, 1'b1);
        @(posedge clk); #1;
        check("wrap_00", {q1, q0}, 8'h00);
        check("wrap_max", max_tick, 1'b0);
        tick = 1'b0;
        @(posedge clk); #1;

        // Test 4: hold at 37 for 50 cycles
        do_reset();
        pulse(37);
        for (int i = 0; i < 50; i++) begin
            check($sformatf("hold37_%0d", i), {q1, q0, 3'b000, max_tick}, {8'h37, 4'h0});
            @(posedge clk); #1;
        end

        // Test 5: continuous tick for 120 edges
        do_reset();
        @(posedge clk); #1;
        max_cnt = 0;
        tick = 1'b1;
        for (int i = 0; i < 120; i++) begin
            #1;
            if (max_tick) max_cnt++;
            @(posedge clk); #1;
        end
        tick = 1'b0;
        #1;
`ifdef DEM_BCD_TICK_EDGE_EN
        check("cont_end", {q1, q0}, 8'h01);
        check("cont_max_cnt", max_cnt, 0);
`else
        check("cont_end", {q1, q0}, 8'h00);
        check("cont_max_cnt", max_cnt, 2);
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/dem_bcd_0_59.md
Name: dem_bcd_0_59

Overview:
Two-digit BCD up-counter, 00 to 59, then wraps to 00; used as a seconds or minutes field driving the TM1638 display.
- Advances one count per qualified tick; clocked by the system clock.
- Outputs units and tens BCD digits.
- Outputs a carry strobe so instances can be cascaded, for example seconds into minutes.

Parameters:
- UNITS_MAX, 9: terminal value of the units digit (0-9).
- TENS_MAX, 5: terminal value of the tens digit (0-9); default gives modulo-60.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- tick, input, 1: count enable, sampled on the rising edge of clk.
- q1, output, 4: tens digit, BCD, registered.
- q0, output, 4: units digit, BCD, registered.
- max_tick, output, 1: carry strobe, combinational; high when q1==TENS_MAX, q0==UNITS_MAX and the tick is qualified.

Behaviour:
Clock and reset:
- One clock (clk). Reset (reset) is asynchronous and active-high.
- While reset=1: q1=0, q0=0 immediately, no clock needed; max_tick=0.
- The counter holds 00 for every edge while reset is asserted.
- Reset deassertion is synchronised by the user; the first qualified tick after release gives 01.

Tick qualification:
- Default: level-sensitive. Every rising clk edge with tick=1 is one count.
- tick=1 for N edges gives N counts.

Counting:
- Per qualified tick:
  - If q0 < UNITS_MAX: q0 <= q0+1.
  - Else q0 <= 0 and the tens digit steps:
    - If q1 < TENS_MAX: q1 <= q1+1.
    - Else q1 <= 0, giving a wrap from 59 to 00.
- No qualified tick: both digits hold.
- Latency: the output changes on the same clk edge that samples the qualified tick.

Illegal states:
- Illegal digit values (q0 > UNITS_MAX or q1 > TENS_MAX) are unreachable from reset.
- If present anyway, the next qualified tick forces 00, and max_tick stays 0.

max_tick:
- max_tick = qualified_tick && q1==TENS_MAX && q0==UNITS_MAX.
- It is high during the cycle before the 59->00 edge.
- It must not glitch from q changes within the cycle.

Widths and arithmetic:
- 4-bit unsigned only; no binary-to-BCD conversion needed.

Optional Feature:
Macro: DEM_BCD_TICK_EDGE_EN
- Defined:
  - tick is registered (tick_d, reset to 0).
  - The qualified tick is tick && !tick_d, a rising-edge detect, so a tick held high for many cycles counts exactly once.
  - max_tick uses the edge-qualified tick.
- Undefined:
  - Level-sensitive qualification as above; no extra flop.

Test Plan:
1. Reset mid-count: clk period 20 ns; hold at 00 with reset=0 for 100 ns, assert reset for 100 ns, release. Assert reset again when the count is 23 -> q1/q0 go to 0/0 asynchronously, before the next clk edge.
2. Level-sensitive counting: tick toggling every 20 ns (high on alternate clk edges), macro off -> count advances once per 40 ns; after 10 qualified ticks q1=1, q0=0.
3. Full wrap: apply 59 qualified ticks -> q1=5, q0=9 and max_tick=1 while tick=1. The 60th tick gives q1=0, q0=0 and max_tick=0 on the following cycle.
4. Hold: tick=0 for 50 cycles at count 37 -> q1=3, q0=7 unchanged, max_tick=0 throughout.
5. Continuous tick: tick=1 for 120 consecutive edges from 00 -> two full wraps, ending at 00; max_tick high exactly 2 cycles. With DEM_BCD_TICK_EDGE_EN defined, the same stimulus gives only one count, ending at 01.
6. Parameters: UNITS_MAX=9, TENS_MAX=2 (modulo-30) -> 29 wraps to 00; max_tick is asserted at 29.
